// File: rtl/jtsdram_responder_if.sv
// jtsdram request/response bundle.
// One prog port and four bank ports (bank 0 also writes). Requests are level
// signals held by the requester until its ack. ack/rdy are 1-cycle pulses.
// data_read is shared by every port and busy flags a transaction in flight.
// master : requester side (drives addr/data/requests, sees ack/rdy/data)
// slave  : responder side (jtsdram_responder)
interface jtsdram_if;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        prog_rd;
    logic        prog_ack;
    logic        prog_rdy;

    logic [21:0] ba0_addr;
    logic [21:0] ba1_addr;
    logic [21:0] ba2_addr;
    logic [21:0] ba3_addr;
    logic        ba0_rd;
    logic        ba1_rd;
    logic        ba2_rd;
    logic        ba3_rd;
    logic        ba0_wr;
    logic [15:0] ba0_din;
    logic [1:0]  ba0_din_m;
    logic        ba0_ack;
    logic        ba1_ack;
    logic        ba2_ack;
    logic        ba3_ack;
    logic        ba0_rdy;
    logic        ba1_rdy;
    logic        ba2_rdy;
    logic        ba3_rdy;

    logic [31:0] data_read;
    logic        busy;

    modport master (
        output prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
        output ba0_addr, ba1_addr, ba2_addr, ba3_addr,
        output ba0_rd, ba1_rd, ba2_rd, ba3_rd, ba0_wr, ba0_din, ba0_din_m,
        input  prog_ack, prog_rdy,
        input  ba0_ack, ba1_ack, ba2_ack, ba3_ack,
        input  ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy,
        input  data_read, busy
    );

    modport slave (
        input  prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
        input  ba0_addr, ba1_addr, ba2_addr, ba3_addr,
        input  ba0_rd, ba1_rd, ba2_rd, ba3_rd, ba0_wr, ba0_din, ba0_din_m,
        output prog_ack, prog_rdy,
        output ba0_ack, ba1_ack, ba2_ack, ba3_ack,
        output ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy,
        output data_read, busy
    );
endinterface

// File: rtl/jtsdram_responder.sv
// jtsdram_responder: on-chip stand-in for the SDRAM behind the jtsdram
// bank/prog request protocol. Serves one transaction at a time from a
// 4 x 2^AW x 16-bit RAM. ack comes one cycle after the request is seen in
// IDLE, and rdy comes RD_LAT cycles after ack.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    jtsdram_if slave: prog/bank requests in; ack/rdy, data_read, busy out
//
// state | meaning
// IDLE  | arbitrating; prog first, then banks round-robin from ptr
// WAIT  | ack issued, down-counting to the rdy cycle
// DONE  | last cycle before rdy; RAM write / read capture at its end
module jtsdram_responder #(
    parameter int AW     = 10,
    parameter int RD_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    jtsdram_if.slave   bus
);
    localparam int DEPTH = 4 << AW;
    // WAIT lasts RD_LAT-1 cycles: counter runs CNT_LOAD..0
    localparam logic [3:0] CNT_LOAD = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [1:0]  ptr, ptr_next;
    logic [4:0]  grant;      // one-hot; [4] = prog, [3:0] = banks
    logic [4:0]  rdy_next;
    logic [4:0]  ack_q, rdy_q;
    logic        load;
    logic        found;
    logic [1:0]  idx;
    logic        prog_req;
    logic [3:0]  bank_req;

    logic          req_wr;
    logic [1:0]    req_bank;
    logic [AW-1:0] req_addr;
    logic [15:0]   req_data;
    logic [1:0]    req_mask;

    logic [4:0]    lat_port;
    logic          lat_wr;
    logic [1:0]    lat_bank;
    logic [AW-1:0] lat_addr;
    logic [15:0]   lat_data;
    logic [1:0]    lat_mask;

    logic [7:0]    mem_lo [0:DEPTH-1];
    logic [7:0]    mem_hi [0:DEPTH-1];
    logic [AW+1:0] idx0, idx1;
    logic [31:0]   data_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.prog_addr[21:AW], bus.ba0_addr[21:AW],
                                bus.ba1_addr[21:AW], bus.ba2_addr[21:AW],
                                bus.ba3_addr[21:AW]};

    assign prog_req = bus.prog_we | bus.prog_rd;
    assign bank_req = {bus.ba3_rd, bus.ba2_rd, bus.ba1_rd, bus.ba0_rd | bus.ba0_wr};

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ptr_next   = ptr;
        grant      = '0;
        rdy_next   = '0;
        load       = 1'b0;
        found      = 1'b0;
        idx        = '0;
        case (state)
            IDLE: begin
                if (prog_req) begin
                    grant[4] = 1'b1;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        idx = ptr + 2'(i);
                        if (!found && bank_req[idx]) begin
                            found      = 1'b1;
                            grant[idx] = 1'b1;
                            ptr_next   = idx + 2'd1;
                        end
                    end
                end
                if (|grant) begin
                    load       = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = (RD_LAT == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_next = DONE;
                else             cnt_next   = cnt - 4'd1;
            end
            DONE: begin
                rdy_next   = lat_port;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            ack_q <= '0;
            rdy_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ptr   <= ptr_next;
            ack_q <= grant;
            rdy_q <= rdy_next;
        end
    end

    // Request mux for the winner; simultaneous we+rd resolves to a write
    always_comb begin
        req_wr   = 1'b0;
        req_bank = '0;
        req_addr = '0;
        req_data = '0;
        req_mask = 2'b11;
        if (grant[4]) begin
            req_wr   = bus.prog_we;
            req_bank = bus.prog_ba;
            req_addr = bus.prog_addr[AW-1:0];
            req_data = bus.prog_data;
            req_mask = bus.prog_mask;
        end else if (grant[0]) begin
            req_wr   = bus.ba0_wr;
            req_bank = 2'd0;
            req_addr = bus.ba0_addr[AW-1:0];
            req_data = bus.ba0_din;
            req_mask = bus.ba0_din_m;
        end else if (grant[1]) begin
            req_bank = 2'd1;
            req_addr = bus.ba1_addr[AW-1:0];
        end else if (grant[2]) begin
            req_bank = 2'd2;
            req_addr = bus.ba2_addr[AW-1:0];
        end else if (grant[3]) begin
            req_bank = 2'd3;
            req_addr = bus.ba3_addr[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            lat_port <= grant;
            lat_wr   <= req_wr;
            lat_bank <= req_bank;
            lat_addr <= req_addr;
            lat_data <= req_data;
            lat_mask <= req_mask;
        end
    end

    assign idx0 = {lat_bank, lat_addr};
    assign idx1 = {lat_bank, lat_addr + AW'(1)};   // wraps within the bank

    // Write lands at the DONE->rdy edge; a reset on that edge drops it
    always_ff @(posedge clk) begin
        if (rst_n && state == DONE && lat_wr) begin
            if (!lat_mask[0]) mem_lo[idx0] <= lat_data[7:0];
            if (!lat_mask[1]) mem_hi[idx0] <= lat_data[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (state == DONE && !lat_wr) begin
            data_q <= {mem_hi[idx1], mem_lo[idx1], mem_hi[idx0], mem_lo[idx0]};
        end
    end

    assign bus.prog_ack  = ack_q[4];
    assign bus.ba0_ack   = ack_q[0];
    assign bus.ba1_ack   = ack_q[1];
    assign bus.ba2_ack   = ack_q[2];
    assign bus.ba3_ack   = ack_q[3];
    assign bus.prog_rdy  = rdy_q[4];
    assign bus.ba0_rdy   = rdy_q[0];
    assign bus.ba1_rdy   = rdy_q[1];
    assign bus.ba2_rdy   = rdy_q[2];
    assign bus.ba3_rdy   = rdy_q[3];
    assign bus.data_read = data_q;
    assign bus.busy      = (state != IDLE);
endmodule
